// File: rtl/serial_add_ctrl_fa_cell.sv
// fa_cell: combinational 1-bit full adder time-shared by serial_add_ctrl.
module fa_cell (
   input  logic x,
   input  logic y,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = x ^ y ^ ci;
   assign co = (x & y) | (ci & (x ^ y));
endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial WIDTH-bit adder, LSB first, one bit per clock through a single fa_cell.
module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);
   localparam int CW = $clog2(WIDTH);
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
   state_t state, state_nx;
   logic [CW-1:0] cnt;
   logic [WIDTH-1:0] a_sr, b_sr, work;
   logic carry, carry_msb_in, s, c, accept, last;
   fa_cell u_fa (.x(a_sr[0]), .y(b_sr[0]), .ci(carry), .s(s), .co(c));
   assign accept = (state != RUN) && start && !abort;
   assign last   = cnt == CW'(WIDTH - 1);
   assign busy   = state == RUN;
   assign done   = state == DONE;
   always_comb begin
      state_nx = (state == RUN) ? (abort ? IDLE : last ? DONE : RUN) : accept ? RUN : IDLE;
   end
   // work is a private accumulator so an abort never disturbs the published result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         cnt          <= '0;
         a_sr         <= '0;
         b_sr         <= '0;
         work         <= '0;
         carry        <= 1'b0;
         carry_msb_in <= 1'b0;
         sum          <= '0;
         cout         <= 1'b0;
         ovf          <= 1'b0;
      end else begin
         state <= state_nx;
         if (accept) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= cin;
            cnt   <= '0;
         end else if (state == RUN && !abort) begin
            a_sr  <= a_sr >> 1;
            b_sr  <= b_sr >> 1;
            work  <= {s, work[WIDTH-1:1]};
            carry <= c;
            cnt   <= last ? '0 : cnt + CW'(1);
            // carry produced by bit WIDTH-2 is the carry into the MSB
            if (cnt == CW'(WIDTH - 2)) carry_msb_in <= c;
            if (last) begin
               sum  <= {s, work[WIDTH-1:1]};
               cout <= c;
               ovf  <= carry_msb_in ^ c;
            end
         end
      end
   end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed and random checks of serial_add_ctrl against an arithmetic reference.
module tb_serial_add_ctrl;
   localparam int W = 8;
   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, cin = 1'b0;
   logic [W-1:0] a = '0, b = '0, sum;
   logic busy, done, cout, ovf;
   int vecs = 0, errs = 0;
   int n, bc, dc;
   logic [W+1:0] r;

   always #5 clk = ~clk;

   serial_add_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .a(a), .b(b), .cin(cin),
      .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
   );

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // {ovf, cout, sum} from signed/unsigned integer arithmetic
   function automatic logic [W+1:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
      int sx, sy, ss;
      logic [W:0] u;
      sx = int'($signed(x));
      sy = int'($signed(y));
      ss = sx + sy + int'(ci);
      u  = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
      return {(ss > 2**(W-1) - 1) || (ss < -(2**(W-1))), u};
   endfunction

   task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
      @(negedge clk);
      a = x; b = y; cin = ci; start = 1'b1;
      @(negedge clk);
      start = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
   endtask

   task automatic wait_done(output int cyc, output int bcnt);
      cyc = 0; bcnt = 0;
      while (!done && cyc < 40) begin
         if (busy) bcnt++;
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic check_res(input string tag, input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
      logic [W+1:0] e;
      e = ref_add(x, y, ci);
      chk({tag, ".sum"}, 32'(sum), 32'(e[W-1:0]));
      chk({tag, ".cout"}, 32'(cout), 32'(e[W]));
      chk({tag, ".ovf"}, 32'(ovf), 32'(e[W+1]));
   endtask

   task automatic full_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
      int c, q;
      issue(x, y, ci);
      wait_done(c, q);
      chk({tag, ".latency"}, 32'(c), 32'(W));
      check_res(tag, x, y, ci);
   endtask

   initial begin
      @(negedge clk);
      chk("rst.busy", 32'(busy), 0);
      chk("rst.done", 32'(done), 0);
      chk("rst.sum", 32'(sum), 0);
      chk("rst.cout", 32'(cout), 0);
      chk("rst.ovf", 32'(ovf), 0);
      rst_n = 1'b1;

      issue(8'h5A, 8'h33, 1'b0);
      wait_done(n, bc);
      chk("t1.latency", 32'(n), 32'(W));
      chk("t1.busy_cycles", 32'(bc), 32'(W));
      chk("t1.sum_const", 32'(sum), 32'h8D);
      chk("t1.ovf_const", 32'(ovf), 1);
      check_res("t1", 8'h5A, 8'h33, 1'b0);
      @(negedge clk);
      chk("t1.done_pulse", 32'(done), 0);

      full_op("t2", 8'hFF, 8'h01, 1'b0);
      chk("t2.cout_const", 32'(cout), 1);
      full_op("t3", 8'h7F, 8'h00, 1'b1);
      chk("t3.sum_const", 32'(sum), 32'h80);

      full_op("t4", 8'h01, 8'h02, 1'b0);
      issue(8'hAA, 8'h55, 1'b0);
      repeat (3) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort.busy", 32'(busy), 0);
      dc = 0;
      for (int i = 0; i < 12; i++) begin
         if (done) dc++;
         @(negedge clk);
      end
      chk("abort.no_done", 32'(dc), 0);
      chk("abort.sum_kept", 32'(sum), 32'h03);

      issue(8'h12, 8'h34, 1'b0);
      wait_done(n, bc);
      check_res("b2b_old", 8'h12, 8'h34, 1'b0);
      a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("b2b.no_idle", 32'(busy), 1);
      wait_done(n, bc);
      chk("b2b.spacing", 32'(n + 1), 32'(W + 1));
      chk("b2b.sum", 32'(sum), 32'h30);

      issue(8'h21, 8'h42, 1'b1);
      a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
      repeat (2) @(negedge clk);
      start = 1'b0;
      wait_done(n, bc);
      check_res("ignore", 8'h21, 8'h42, 1'b1);

      issue(8'hC3, 8'hC3, 1'b1);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst.busy", 32'(busy), 0);
      chk("arst.done", 32'(done), 0);
      chk("arst.sum", 32'(sum), 0);
      chk("arst.cout", 32'(cout), 0);
      chk("arst.ovf", 32'(ovf), 0);
      @(negedge clk);
      a = 8'h0F; b = 8'h01; cin = 1'b0; start = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(n, bc);
      chk("arst.latency", 32'(n), 32'(W));
      chk("arst.sum_after", 32'(sum), 32'h10);

      for (int i = 0; i < 25; i++) begin
         logic [W-1:0] x, y;
         logic ci;
         x = W'($urandom); y = W'($urandom); ci = 1'($urandom);
         full_op("rand", x, y, ci);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
